grf_wb_arbiter: RTL
===================

Name: grf_wb_arbiter

Overview:
Shares the single register-file write port (WE3/A3/WD3/WPC) between N_REQ write-back producers, e.g. ALU, load unit and multiply/divide unit. Grants one write per cycle using round-robin priority and drives the register-file write port through one register stage. Publishes a pending-write mask for the hazard unit. Sits between the execute/memory stages and the register file.

Parameters:
N_REQ, 3, number of write-back requesters (2..8)
AW, 5, register address width
DW, 32, data width and PC width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
req_valid  in  N_REQ  per-requester write request
req_addr  in  N_REQ*AW  packed destination register, slot i at [i*AW +: AW]
req_data  in  N_REQ*DW  packed write data
req_pc  in  N_REQ*DW  packed PC of the producing instruction
req_ready  out  N_REQ  one-hot or zero; request i accepted this cycle
wb_we  out  1  register-file write enable (drives WE3)
wb_addr  out  AW  drives A3
wb_data  out  DW  drives WD3
wb_pc  out  DW  drives WPC
pend_mask  out  2**AW  bit r set = a write to register r is granted but not yet retired
conflict_err  out  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous): wb_we=0, wb_addr=0, wb_data=0, wb_pc=0, pend_mask=0, conflict_err=0, rr_ptr=0. req_ready is 0 while reset is asserted.
- Handshake: a requester holds valid/addr/data/pc stable until it sees req_ready[i]=1 in the same cycle. Transfer happens at the rising edge where valid & ready are both 1. req_ready is combinational from req_valid and rr_ptr.
- Zero-register requests: valid with addr==0 get ready=1 in the same cycle. They do not take the grant slot and never produce wb_we. This can coincide with one nonzero grant, so req_ready can have more than one bit set.
- Arbitration among nonzero-address valids: scan from rr_ptr upward, modulo N_REQ. The first valid wins and only that one gets ready. On a grant to index g, rr_ptr <= (g+1) mod N_REQ. With no grant, rr_ptr holds.
- Latency: when i is granted at edge t, the outputs from edge t are wb_we=1, wb_addr/data/pc = the request's values. The register file writes at edge t+1. With no grant at edge t, wb_we <= 0 and addr/data/pc hold.
- pend_mask is combinational: bit wb_addr is set while wb_we=1, otherwise 0. It covers only the one in-flight registered write; ungranted requests are not included.
- Throughput: one nonzero write per cycle. With all N_REQ valid continuously, each requester is granted exactly once every N_REQ cycles; no starvation.
- Conflict: if two or more valid requests present the same nonzero address in one cycle, conflict_err <= 1 and stays 1 until reset. Arbitration proceeds normally.
- Reset mid-operation: an in-flight registered write is discarded (wb_we forced 0 asynchronously). Pending requests are not remembered.

Decomposition:
- Shared package: AW, DW, N_REQ defaults and requester index constants (REQ_ALU=0, REQ_MEM=1, REQ_MDU=2).
- One sub-module, rr_arbiter: N-bit round-robin grant with pointer update. Inputs are the request vector and pointer; outputs are the one-hot grant and next pointer. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset then idle: reset=0 → all outputs 0. Release reset with no valid → wb_we stays 0 for 10 cycles.
- Single write: req0 addr=5 data=32'h12345678 pc=32'h00003000 for 1 cycle → ready0=1 that cycle; next cycle wb_we=1, wb_addr=5, wb_data=12345678, wb_pc=3000, pend_mask[5]=1; the cycle after, wb_we=0.
- Round-robin: all three held valid with addrs 1, 2, 3 from rr_ptr=0 → grants in order 0,1,2,0,1,2 on consecutive cycles; wb_we=1 every cycle.
- Zero register: req1 addr=0 and req2 addr=7 both valid → ready1=1 and ready2=1 in the same cycle; only addr 7 appears on the write port.
- Conflict: req0 and req2 both addr=9 → conflict_err=1 next cycle and stays 1 through later traffic; req0 granted first, req2 on a following cycle.
- Async reset mid-write: assert reset between edges while wb_we=1 → wb_we=0 immediately; after release, rr_ptr=0.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: default sizing,
// requester slot indices and a small modulo helper for the round-robin scan.
package grf_wb_arbiter_pkg;

   localparam int N_REQ_DEF = 3;
   localparam int AW_DEF    = 5;
   localparam int DW_DEF    = 32;

   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;
   localparam int REQ_MDU = 2;

   // Wraps an index that is known to be below 2*n back into 0..n-1.
   function automatic int wrap_idx(input int idx, input int n);
      return (idx >= n) ? (idx - n) : idx;
   endfunction

endpackage

// File: rtl/grf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: scans upward from ptr_i (mod N) and
// returns a one-hot grant plus the pointer that follows the winner.
module grf_wb_arbiter_rr_arbiter
   import grf_wb_arbiter_pkg::*;
#(
   parameter int N  = N_REQ_DEF,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          gnt_valid_o,
   output logic [PW-1:0] ptr_nxt_o
);

   logic [PW-1:0] sel_s;
   logic          hit_s;

   // First requester at or after the pointer wins; later hits are masked.
   always_comb begin
      gnt_o       = {N{1'b0}};
      gnt_valid_o = 1'b0;
      ptr_nxt_o   = ptr_i;
      sel_s       = {PW{1'b0}};
      hit_s       = 1'b0;
      for (int k = 0; k < N; k++) begin
         sel_s        = PW'(wrap_idx(int'(ptr_i) + k, N));
         hit_s        = ~gnt_valid_o & req_i[sel_s];
         gnt_o[sel_s] = gnt_o[sel_s] | hit_s;
         ptr_nxt_o    = hit_s ? PW'(wrap_idx(int'(sel_s) + 1, N)) : ptr_nxt_o;
         gnt_valid_o  = gnt_valid_o | hit_s;
      end
   end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N_REQ
// write-back producers, with one register stage and a pending-write mask.
module grf_wb_arbiter
   import grf_wb_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_data,
   input  logic [N_REQ*DW-1:0] req_pc,
   output logic [N_REQ-1:0]    req_ready,
   output logic                wb_we,
   output logic [AW-1:0]       wb_addr,
   output logic [DW-1:0]       wb_data,
   output logic [DW-1:0]       wb_pc,
   output logic [(2**AW)-1:0]  pend_mask,
   output logic                conflict_err
);

   localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int NREG = 2**AW;

   logic [N_REQ-1:0] nz_req_s, zero_req_s, gnt_s;
   logic             gnt_valid_s, conflict_s;
   logic [PW-1:0]    ptr_nxt_s;
   logic [AW-1:0]    sel_addr_s;
   logic [DW-1:0]    sel_data_s, sel_pc_s;

   logic             wb_we_q, wb_we_d, conflict_q, conflict_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic [DW-1:0]    wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

   // Writes to r0 are acknowledged at once and never compete for the port.
   always_comb begin
      nz_req_s   = {N_REQ{1'b0}};
      zero_req_s = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         nz_req_s[i]   = req_valid[i] & (req_addr[i*AW +: AW] != {AW{1'b0}});
         zero_req_s[i] = req_valid[i] & (req_addr[i*AW +: AW] == {AW{1'b0}});
      end
   end

   grf_wb_arbiter_rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
      .req_i       (nz_req_s),
      .ptr_i       (rr_ptr_q),
      .gnt_o       (gnt_s),
      .gnt_valid_o (gnt_valid_s),
      .ptr_nxt_o   (ptr_nxt_s)
   );

   // Grant is one-hot, so an AND-OR mux selects the winning payload.
   always_comb begin
      sel_addr_s = {AW{1'b0}};
      sel_data_s = {DW{1'b0}};
      sel_pc_s   = {DW{1'b0}};
      conflict_s = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_addr_s = sel_addr_s | ({AW{gnt_s[i]}} & req_addr[i*AW +: AW]);
         sel_data_s = sel_data_s | ({DW{gnt_s[i]}} & req_data[i*DW +: DW]);
         sel_pc_s   = sel_pc_s   | ({DW{gnt_s[i]}} & req_pc[i*DW +: DW]);
         for (int j = i + 1; j < N_REQ; j++) begin
            conflict_s = conflict_s | (nz_req_s[i] & nz_req_s[j] &
                         (req_addr[i*AW +: AW] == req_addr[j*AW +: AW]));
         end
      end
   end

   assign req_ready = reset ? (gnt_s | zero_req_s) : {N_REQ{1'b0}};

   always_comb begin
      wb_we_d    = gnt_valid_s;
      conflict_d = conflict_q | conflict_s;
      if (gnt_valid_s) begin
         wb_addr_d = sel_addr_s;
         wb_data_d = sel_data_s;
         wb_pc_d   = sel_pc_s;
         rr_ptr_d  = ptr_nxt_s;
      end else begin
         wb_addr_d = wb_addr_q;
         wb_data_d = wb_data_q;
         wb_pc_d   = wb_pc_q;
         rr_ptr_d  = rr_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_we_q    <= 1'b0;
         wb_addr_q  <= {AW{1'b0}};
         wb_data_q  <= {DW{1'b0}};
         wb_pc_q    <= {DW{1'b0}};
         rr_ptr_q   <= {PW{1'b0}};
         conflict_q <= 1'b0;
      end else begin
         wb_we_q    <= wb_we_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         wb_pc_q    <= wb_pc_d;
         rr_ptr_q   <= rr_ptr_d;
         conflict_q <= conflict_d;
      end
   end

   // Only the single in-flight registered write is reported to hazard logic.
   always_comb begin
      pend_mask = {NREG{1'b0}};
      if (wb_we_q) begin
         pend_mask[wb_addr_q] = 1'b1;
      end else begin
         pend_mask = {NREG{1'b0}};
      end
   end

   assign wb_we        = wb_we_q;
   assign wb_addr      = wb_addr_q;
   assign wb_data      = wb_data_q;
   assign wb_pc        = wb_pc_q;
   assign conflict_err = conflict_q;

endmodule
